// File: rtl/apb_vic_pkg.sv
// Shared constants for the APB vectored interrupt controller: register
// offsets, sizing and a helper for popping the in-service priority mask.
package vic_pkg;

    localparam int NUM_SRC         = 32;
    localparam int NUM_VECT        = 16;
    localparam int NUM_LEVELS      = NUM_VECT + 1;
    localparam int DEF_LEVEL       = NUM_VECT;
    localparam int VECTCNTL_EN_BIT = 5;

    localparam logic [11:0] VIC_IRQSTATUS     = 12'h000;
    localparam logic [11:0] VIC_FIQSTATUS     = 12'h004;
    localparam logic [11:0] VIC_RAWINTR       = 12'h008;
    localparam logic [11:0] VIC_INTSELECT     = 12'h00C;
    localparam logic [11:0] VIC_INTENABLE     = 12'h010;
    localparam logic [11:0] VIC_INTENCLEAR    = 12'h014;
    localparam logic [11:0] VIC_SOFTINT       = 12'h018;
    localparam logic [11:0] VIC_SOFTINTCLEAR  = 12'h01C;
    localparam logic [11:0] VIC_VECTADDR      = 12'h030;
    localparam logic [11:0] VIC_DEFVECTADDR   = 12'h034;
    localparam logic [11:0] VIC_VECTADDR_BASE = 12'h100;
    localparam logic [11:0] VIC_VECTCNTL_BASE = 12'h200;

    typedef logic [5:0] vect_cntl_t;

    // Lowest set bit is the highest-priority level in service; drop it.
    function automatic logic [NUM_LEVELS-1:0] clear_lowest(input logic [NUM_LEVELS-1:0] m);
        return m & (m - 1'b1);
    endfunction

endpackage

// File: rtl/apb_vic_if.sv
// APB bus bundle between the CPU-side master and the VIC slave.
interface apb_vic_if;
    logic        pselVIC;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport slave  (input pselVIC, penable, paddr, pwrite, pwdata, output prdata);
    modport master (output pselVIC, penable, paddr, pwrite, pwdata, input prdata);
endinterface

// File: rtl/apb_vic_prio.sv
// Combinational priority resolver: finds the highest-priority IRQ level
// (slots 0..15, default 16) that is not masked by the in-service mask.
module vic_prio
    import vic_pkg::*;
(
    input  logic [NUM_SRC-1:0]    irq_status,
    input  vect_cntl_t            vect_cntl [NUM_VECT],
    input  logic [NUM_LEVELS-1:0] in_service,
    output logic                  eligible,
    output logic [4:0]            level,
    output logic [3:0]            vect_sel
);

    logic [NUM_SRC-1:0]    claimed;
    logic [NUM_LEVELS-1:0] req;
    logic                  blocked;

    // Build per-level requests, then pick the lowest unblocked level.
    always_comb begin
        claimed  = '0;
        req      = '0;
        blocked  = 1'b0;
        eligible = 1'b0;
        level    = '0;
        for (int n = 0; n < NUM_VECT; n++) begin
            if (vect_cntl[n][VECTCNTL_EN_BIT]) begin
                claimed[vect_cntl[n][4:0]] = 1'b1;
                req[n] = irq_status[vect_cntl[n][4:0]];
            end
        end
        req[DEF_LEVEL] = |(irq_status & ~claimed);
        // An in-service bit at level k blocks level k and everything below it.
        for (int l = 0; l < NUM_LEVELS; l++) begin
            blocked = blocked | in_service[l];
            if (!eligible && req[l] && !blocked) begin
                eligible = 1'b1;
                level    = 5'(l);
            end
        end
        vect_sel = level[3:0];
    end

endmodule

// File: rtl/apb_vic.sv
// APB vectored interrupt controller: register file, APB decode, hardware
// in-service mask for IRQ nesting and registered nFIQ/nIRQ outputs.
module apb_vic
    import vic_pkg::*;
(
    input  logic               pclk,
    input  logic               presetn,
    apb_vic_if.slave           apb,
    input  logic [NUM_SRC-1:0] VICIntSource,
    output logic               nvicfiq,
    output logic               nvicirq
);

    logic [11:0] addr_w;
    logic        unused_addr_bits;
    logic        wr_en;
    logic        rd_access;
    logic        slot_va_hit;
    logic        slot_vc_hit;
    logic [3:0]  slot_idx;

    logic [NUM_SRC-1:0]    int_sel_q,  int_sel_d;
    logic [NUM_SRC-1:0]    int_en_q,   int_en_d;
    logic [NUM_SRC-1:0]    soft_int_q, soft_int_d;
    logic [31:0]           def_vect_q, def_vect_d;
    logic [31:0]           vect_hold_q, vect_hold_d;
    logic [31:0]           vect_addr_q [NUM_VECT];
    logic [31:0]           vect_addr_d [NUM_VECT];
    vect_cntl_t            vect_cntl_q [NUM_VECT];
    vect_cntl_t            vect_cntl_d [NUM_VECT];
    logic [NUM_LEVELS-1:0] in_service_q, in_service_d;
    logic                  fiq_n_q, fiq_n_d;
    logic                  irq_n_q, irq_n_d;

    logic [NUM_SRC-1:0] raw_intr;
    logic [NUM_SRC-1:0] irq_status;
    logic [NUM_SRC-1:0] fiq_status;
    logic               eligible;
    logic [4:0]         win_level;
    logic [3:0]         vect_sel;
    logic [31:0]        vect_rd;

    assign addr_w           = {apb.paddr[11:2], 2'b00};
    assign unused_addr_bits = ^{apb.paddr[31:12], apb.paddr[1:0]};
    assign wr_en            = apb.pselVIC & apb.penable & apb.pwrite;
    assign rd_access        = apb.pselVIC & apb.penable & ~apb.pwrite;
    assign slot_va_hit      = (addr_w[11:6] == VIC_VECTADDR_BASE[11:6]);
    assign slot_vc_hit      = (addr_w[11:6] == VIC_VECTCNTL_BASE[11:6]);
    assign slot_idx         = addr_w[5:2];

    assign raw_intr   = VICIntSource | soft_int_q;
    assign irq_status = raw_intr & int_en_q & ~int_sel_q;
    assign fiq_status = raw_intr & int_en_q & int_sel_q;

    vic_prio u_prio (
        .irq_status (irq_status),
        .vect_cntl  (vect_cntl_q),
        .in_service (in_service_q),
        .eligible   (eligible),
        .level      (win_level),
        .vect_sel   (vect_sel)
    );

    // Vector presented on a VectAddr read; holds the last one when idle.
    always_comb begin
        vect_rd = vect_hold_q;
        if (eligible) begin
            vect_rd = (win_level == 5'(DEF_LEVEL)) ? def_vect_q : vect_addr_q[vect_sel];
        end
    end

    // Combinational read mux, live in both setup and access phases.
    always_comb begin
        apb.prdata = '0;
        if (apb.pselVIC && !apb.pwrite) begin
            case (addr_w)
                VIC_IRQSTATUS:   apb.prdata = irq_status;
                VIC_FIQSTATUS:   apb.prdata = fiq_status;
                VIC_RAWINTR:     apb.prdata = raw_intr;
                VIC_INTSELECT:   apb.prdata = int_sel_q;
                VIC_INTENABLE:   apb.prdata = int_en_q;
                VIC_SOFTINT:     apb.prdata = soft_int_q;
                VIC_VECTADDR:    apb.prdata = vect_rd;
                VIC_DEFVECTADDR: apb.prdata = def_vect_q;
                default: begin
                    if (slot_va_hit) apb.prdata = vect_addr_q[slot_idx];
                    if (slot_vc_hit) apb.prdata = {26'b0, vect_cntl_q[slot_idx]};
                end
            endcase
        end
    end

    // Next state: register writes, in-service push/pop and output flops.
    always_comb begin
        int_sel_d    = int_sel_q;
        int_en_d     = int_en_q;
        soft_int_d   = soft_int_q;
        def_vect_d   = def_vect_q;
        vect_hold_d  = vect_hold_q;
        vect_addr_d  = vect_addr_q;
        vect_cntl_d  = vect_cntl_q;
        in_service_d = in_service_q;
        fiq_n_d      = ~|fiq_status;
        irq_n_d      = ~eligible;
        if (wr_en) begin
            case (addr_w)
                VIC_INTSELECT:    int_sel_d    = apb.pwdata;
                VIC_INTENABLE:    int_en_d     = int_en_q | apb.pwdata;
                VIC_INTENCLEAR:   int_en_d     = int_en_q & ~apb.pwdata;
                VIC_SOFTINT:      soft_int_d   = soft_int_q | apb.pwdata;
                VIC_SOFTINTCLEAR: soft_int_d   = soft_int_q & ~apb.pwdata;
                VIC_VECTADDR:     in_service_d = clear_lowest(in_service_q);
                VIC_DEFVECTADDR:  def_vect_d   = apb.pwdata;
                default: begin
                    if (slot_va_hit) vect_addr_d[slot_idx] = apb.pwdata;
                    if (slot_vc_hit) vect_cntl_d[slot_idx] = apb.pwdata[5:0];
                end
            endcase
        end
        // Reading the vector acknowledges it: mark its level in service.
        if (rd_access && addr_w == VIC_VECTADDR && eligible) begin
            in_service_d[win_level] = 1'b1;
            vect_hold_d             = vect_rd;
        end
    end

    // State registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            int_sel_q    <= '0;
            int_en_q     <= '0;
            soft_int_q   <= '0;
            def_vect_q   <= '0;
            vect_hold_q  <= '0;
            in_service_q <= '0;
            fiq_n_q      <= 1'b1;
            irq_n_q      <= 1'b1;
            for (int n = 0; n < NUM_VECT; n++) begin
                vect_addr_q[n] <= '0;
                vect_cntl_q[n] <= '0;
            end
        end else begin
            int_sel_q    <= int_sel_d;
            int_en_q     <= int_en_d;
            soft_int_q   <= soft_int_d;
            def_vect_q   <= def_vect_d;
            vect_hold_q  <= vect_hold_d;
            in_service_q <= in_service_d;
            fiq_n_q      <= fiq_n_d;
            irq_n_q      <= irq_n_d;
            vect_addr_q  <= vect_addr_d;
            vect_cntl_q  <= vect_cntl_d;
        end
    end

    assign nvicfiq = fiq_n_q;
    assign nvicirq = irq_n_q;

endmodule

// File: tb/tb_apb_vic.sv
// Scoreboard bench for apb_vic: directed nesting scenarios then random
// register/source traffic against a behavioural model with a level stack.
module tb_apb_vic;
    import vic_pkg::*;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [31:0] src;
    logic        nvicfiq;
    logic        nvicirq;

    apb_vic_if apb ();

    apb_vic dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .apb          (apb),
        .VICIntSource (src),
        .nvicfiq      (nvicfiq),
        .nvicirq      (nvicirq)
    );

    always #5 pclk = ~pclk;

    // Behavioural model state
    logic [31:0] m_sel, m_en, m_soft, m_def, m_hold;
    logic [31:0] m_va [16];
    logic [5:0]  m_vc [16];
    int          m_stack [$];

    // Scoreboard
    logic [31:0] rd_exp_q [$];
    string       rd_name_q [$];
    logic [1:0]  pin_exp_q [$];
    string       pin_name_q [$];
    logic        pin_chk = 1'b0;
    logic        done = 1'b0;
    logic        mon_done = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic int m_level();
        logic [31:0] irqs;
        logic [31:0] claimed;
        int          lim;
        irqs    = (src | m_soft) & m_en & ~m_sel;
        lim     = (m_stack.size() == 0) ? 17 : m_stack[$];
        claimed = '0;
        for (int n = 0; n < 16; n++) begin
            if (n < lim && m_vc[n][5] && irqs[m_vc[n][4:0]]) return n;
        end
        for (int n = 0; n < 16; n++) if (m_vc[n][5]) claimed[m_vc[n][4:0]] = 1'b1;
        if (lim > 16 && (irqs & ~claimed) != 0) return 16;
        return -1;
    endfunction

    function automatic logic [31:0] m_vect();
        int l;
        l = m_level();
        if (l < 0) return m_hold;
        if (l == 16) return m_def;
        return m_va[l];
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] raw;
        raw = src | m_soft;
        case (a)
            12'h000: return raw & m_en & ~m_sel;
            12'h004: return raw & m_en & m_sel;
            12'h008: return raw;
            12'h00C: return m_sel;
            12'h010: return m_en;
            12'h018: return m_soft;
            12'h030: return m_vect();
            12'h034: return m_def;
            default: begin
                if (a >= 12'h100 && a <= 12'h13C) return m_va[a[5:2]];
                if (a >= 12'h200 && a <= 12'h23C) return {26'b0, m_vc[a[5:2]]};
                return 32'h0;
            end
        endcase
    endfunction

    task automatic m_read_effect(input logic [11:0] a);
        int l;
        l = m_level();
        if (a == 12'h030 && l >= 0) begin
            m_hold = m_vect();
            m_stack.push_back(l);
        end
    endtask

    task automatic m_write(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h00C: m_sel  = d;
            12'h010: m_en   = m_en | d;
            12'h014: m_en   = m_en & ~d;
            12'h018: m_soft = m_soft | d;
            12'h01C: m_soft = m_soft & ~d;
            12'h030: if (m_stack.size() > 0) void'(m_stack.pop_back());
            12'h034: m_def  = d;
            default: begin
                if (a >= 12'h100 && a <= 12'h13C) m_va[a[5:2]] = d;
                if (a >= 12'h200 && a <= 12'h23C) m_vc[a[5:2]] = d[5:0];
            end
        endcase
    endtask

    task automatic drive_addr(input logic [11:0] a);
        logic [31:0] r;
        r = $urandom();
        apb.paddr = {r[31:12], a[11:2], r[1:0]};
    endtask

    task automatic apb_read(input logic [11:0] a, input string nm, input bit use_k, input logic [31:0] k);
        @(posedge pclk); #1;
        apb.pselVIC = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0;
        drive_addr(a);
        rd_exp_q.push_back(use_k ? k : m_read(a));
        rd_name_q.push_back(nm);
        m_read_effect(a);
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        @(posedge pclk); #1;
        apb.pselVIC = 1'b0; apb.penable = 1'b0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge pclk); #1;
        apb.pselVIC = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
        drive_addr(a);
        apb.pwdata = d;
        @(posedge pclk); #1;
        apb.penable = 1'b1;
        @(posedge pclk); #1;
        apb.pselVIC = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        m_write(a, d);
    endtask

    task automatic check_pins(input string nm, input bit use_k, input logic fiq_k, input logic irq_k);
        logic [31:0] fs;
        @(posedge pclk); #1;
        fs = (src | m_soft) & m_en & m_sel;
        pin_exp_q.push_back(use_k ? {fiq_k, irq_k} : {~|fs, (m_level() < 0)});
        pin_name_q.push_back(nm);
        pin_chk = 1'b1;
        @(negedge pclk); #1;
        pin_chk = 1'b0;
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard.
    always @(negedge pclk) begin
        if (pin_chk) begin
            vectors++;
            if (pin_exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pins: no expectation queued, got fiq=%b irq=%b", nvicfiq, nvicirq);
            end else begin
                logic [1:0] e;
                string      nm;
                e  = pin_exp_q.pop_front();
                nm = pin_name_q.pop_front();
                if ({nvicfiq, nvicirq} !== e) begin
                    miscompares++;
                    $display("FAIL %s: nvicfiq/nvicirq got %b%b expected %b", nm, nvicfiq, nvicirq, e);
                end
            end
        end
        if (apb.pselVIC && apb.penable && !apb.pwrite) begin
            vectors++;
            if (rd_exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL read: no expectation queued, got %h", apb.prdata);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = rd_exp_q.pop_front();
                nm = rd_name_q.pop_front();
                if (apb.prdata !== e) begin
                    miscompares++;
                    $display("FAIL %s: prdata got %h expected %h", nm, apb.prdata, e);
                end
            end
        end
        if (done && !mon_done) begin
            vectors++;
            if (rd_exp_q.size() != 0 || pin_exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL drain: %0d reads and %0d pin checks left unchecked, expected 0",
                         rd_exp_q.size(), pin_exp_q.size());
            end
            mon_done = 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [11:0] ra [14];
        logic [11:0] wa [11];
        logic [11:0] a;
        logic [31:0] d;
        int          op;

        presetn = 1'b0;
        src = '0;
        apb.pselVIC = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0;
        m_sel = '0; m_en = '0; m_soft = '0; m_def = '0; m_hold = '0;
        for (int n = 0; n < 16; n++) begin m_va[n] = '0; m_vc[n] = '0; end
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;

        // Reset state
        check_pins("reset_pins", 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) apb_read(12'(4 * i), "reset_reg", 1'b1, 32'h0);
        apb_read(12'h030, "reset_vectaddr", 1'b1, 32'h0);
        apb_read(12'h034, "reset_defvect", 1'b1, 32'h0);
        for (int n = 0; n < 16; n++) begin
            apb_read(12'h100 + 12'(4 * n), "reset_vectaddrN", 1'b1, 32'h0);
            apb_read(12'h200 + 12'(4 * n), "reset_vectcntlN", 1'b1, 32'h0);
        end

        // Basic registers
        apb_write(12'h100, 32'hFFF00010);
        apb_read(12'h100, "vectaddr0", 1'b1, 32'hFFF00010);
        apb_write(12'h010, 32'h00FFFFFF);
        apb_write(12'h014, 32'h1);
        apb_read(12'h010, "intenable_clear", 1'b1, 32'h00FFFFFE);

        // FIQ path
        apb_write(12'h00C, 32'hFFFF0000);
        apb_write(12'h010, 32'h00010000);
        src = 32'h00010000;
        check_pins("fiq_assert", 1'b1, 1'b0, 1'b1);
        src = 32'h0;
        check_pins("fiq_deassert", 1'b1, 1'b1, 1'b1);

        // Nesting
        apb_write(12'h034, 32'hFFF00000);
        for (int n = 0; n < 15; n++) begin
            apb_write(12'h100 + 12'(4 * n), 32'hFFF00010 + 32'(n));
            apb_write(12'h200 + 12'(4 * n), 32'h20 + 32'(n));
        end
        apb_write(12'h010, 32'hFFFFFFFF);
        src = 32'h8;
        check_pins("nest_src3_irq", 1'b1, 1'b1, 1'b0);
        apb_read(12'h030, "nest_src3_vect", 1'b1, 32'hFFF00013);
        src = 32'h28;
        check_pins("nest_src5_masked", 1'b1, 1'b1, 1'b1);
        src = 32'h29;
        check_pins("nest_src0_preempt", 1'b1, 1'b1, 1'b0);
        apb_read(12'h030, "nest_src0_vect", 1'b1, 32'hFFF00010);
        src = 32'h28;
        apb_write(12'h030, 32'h0);
        check_pins("nest_pop0", 1'b1, 1'b1, 1'b1);
        src = 32'h20;
        apb_write(12'h030, 32'h0);
        check_pins("nest_pop3", 1'b1, 1'b1, 1'b0);
        apb_read(12'h030, "nest_src5_vect", 1'b1, 32'hFFF00015);
        apb_write(12'h030, 32'h0);
        src = 32'h0;
        check_pins("nest_idle", 1'b1, 1'b1, 1'b1);
        apb_read(12'h030, "idle_hold", 1'b1, 32'hFFF00015);

        // Simultaneous sources: lower slot wins
        src = 32'hC0;
        apb_read(12'h030, "simul_6_7", 1'b1, 32'hFFF00016);
        apb_write(12'h030, 32'h0);
        src = 32'h0;

        // Default vector when no slot claims the source
        for (int n = 0; n < 16; n++) apb_write(12'h200 + 12'(4 * n), 32'h0);
        src = 32'h8;
        check_pins("default_irq", 1'b1, 1'b1, 1'b0);
        apb_read(12'h030, "default_vect", 1'b1, 32'hFFF00000);
        apb_write(12'h030, 32'h0);
        src = 32'h0;
        check_pins("default_idle", 1'b1, 1'b1, 1'b1);

        // Random traffic against the model
        ra = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018,
               12'h01C, 12'h030, 12'h034, 12'h020, 12'h300, 12'h100, 12'h200};
        wa = '{12'h00C, 12'h010, 12'h014, 12'h018, 12'h01C, 12'h034, 12'h030,
               12'h100, 12'h200, 12'h020, 12'h000};
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                src = $urandom() & $urandom();
            end else if (op <= 4) begin
                a = wa[$urandom_range(0, 10)];
                if (a == 12'h100 || a == 12'h200) a = a + 12'(4 * $urandom_range(0, 15));
                d = $urandom();
                if (a == 12'h018 || a == 12'h010) d = d & $urandom() & $urandom();
                apb_write(a, d);
            end else if (op <= 6) begin
                apb_read(12'h030, "rand_vectaddr", 1'b0, 32'h0);
            end else if (op == 7) begin
                apb_write(12'h030, $urandom());
            end else begin
                a = ra[$urandom_range(0, 13)];
                if (a == 12'h100 || a == 12'h200) a = a + 12'(4 * $urandom_range(0, 15));
                apb_read(a, "rand_reg", 1'b0, 32'h0);
            end
            check_pins("rand_pins", 1'b0, 1'b0, 1'b0);
        end

        done = 1'b1;
        for (int i = 0; i < 10 && !mon_done; i++) @(posedge pclk);
        if (!mon_done) begin
            $display("FAIL monitor: drain not acknowledged, got 0 expected 1");
            $fatal(1);
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_vic.md
Name: apb_vic

Overview:
- APB slave vectored interrupt controller, register-compatible with the PL190 VIC subset below.
- Takes 32 level-sensitive interrupt sources and steers each to FIQ or IRQ.
- Drives active-low nFIQ/nIRQ to the CPU.
- Provides 16 prioritised vector slots plus a default vector, with hardware priority nesting driven by VectAddr read/write.

Parameters:
- NUM_SRC, 32, number of interrupt sources.
- NUM_VECT, 16, number of vectored slots (slot 0 is highest priority).

Ports:
- pclk  in  1  APB clock; all state updates on its rising edge.
- presetn  in  1  asynchronous active-low reset.
- pselVIC  in  1  APB select.
- penable  in  1  APB enable (access phase).
- paddr  in  32  byte address; only paddr[11:2] is decoded.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- VICIntSource  in  32  interrupt requests, active high, level, synchronous to pclk.
- nvicfiq  out  1  FIQ to CPU, active low.
- nvicirq  out  1  IRQ to CPU, active low.

Behaviour:
- Reset: every register is 0, the in-service stack is empty, nvicfiq=1, nvicirq=1.
- Write strobe: pselVIC & penable & pwrite, committed on the pclk edge.
- Read data: prdata is combinational from paddr whenever pselVIC & !pwrite, valid in both setup and access phases. Otherwise prdata = 0. Unmapped addresses read 0 and ignore writes.
- Register map (offsets):
  - 0x000 IRQStatus (RO) = Raw & En & ~Sel.
  - 0x004 FIQStatus (RO) = Raw & En & Sel.
  - 0x008 RawIntr (RO) = VICIntSource | SoftInt.
  - 0x00C IntSelect (RW), 1 = FIQ.
  - 0x010 IntEnable: write 1 sets a bit, write 0 has no effect; reads return the enable mask.
  - 0x014 IntEnClear (WO), 1 clears the enable bit.
  - 0x018 SoftInt: write-1 sets; reads return the value.
  - 0x01C SoftIntClear (WO), 1 clears.
  - 0x030 VectAddr (RW, with side effects).
  - 0x034 DefVectAddr (RW).
  - 0x100+4n VectAddrN (RW, 32 bits).
  - 0x200+4n VectCntlN (RW): bit5 = enable, bits4:0 = source number; other bits read 0.
- FIQ output:
  - nvicfiq is registered: the next edge gives ~|FIQStatus.
  - FIQ has no vectoring and no nesting.
- Priority levels:
  - Levels 0..15 are vector slots.
  - Level 16 is "default": any IRQStatus bit not claimed by an enabled slot.
  - Slot n is requesting when VectCntlN.bit5 = 1 and IRQStatus[VectCntlN[4:0]] = 1.
  - If several slots name the same source, the lowest slot wins.
- In-service stack: a 17-bit in-service mask, one bit per level.
  - A level L request is eligible only if no in-service bit at a level <= L is set.
  - Effect: equal and lower priorities are masked; higher priorities preempt.
- IRQ output: nvicirq is registered; the next edge gives ~(any eligible request). Latency is one pclk from a source change or a mask change.
- VectAddr read value: VectAddrN of the highest eligible slot. If only the default level is eligible, DefVectAddr. If nothing is eligible, the last value returned (held register; 0 after reset).
- VectAddr read side effect: an access-phase read of 0x030 sets the in-service bit of the returned level. Nothing changes if nothing is eligible.
- VectAddr write: an access-phase write to 0x030 (data ignored) clears the highest-priority set in-service bit. A write with an empty stack is a no-op.
- Sources are not latched. A request that drops before service simply disappears and nvicirq deasserts one cycle later.

Decomposition:
- Package vic_pkg:
  - register offset constants (VIC_IRQSTATUS … VIC_VECTCNTL_BASE);
  - NUM_SRC, NUM_VECT;
  - VECTCNTL_EN_BIT = 5.
- One sub-module, vic_prio: combinational priority resolver.
  - Inputs: IRQStatus, VectCntl array, in-service mask.
  - Outputs: eligible flag, winning level (0..16), vector select.
- Top level holds the APB decode, the registers, the stack and the output flops.

Test Plan:
- Reset, then read every register -> all 0; nvicfiq = nvicirq = 1.
- Write VectAddr0 = 0xFFF00010, read 0x100 -> 0xFFF00010.
- Write IntEnable = 0x00FFFFFF, then IntEnClear = 0x1 -> IntEnable reads 0x00FFFFFE.
- FIQ path: IntSelect = 0xFFFF0000, enable source 16, assert it -> nvicfiq = 0 one cycle later, nvicirq = 1; deassert -> nvicfiq = 1.
- Nesting setup: IntSelect = 0xFFFF0000, DefVect = 0xFFF00000, VectAddrN = 0xFFF00010+N, VectCntlN = 0x20+N for N = 0..14, all enabled. Then:
  - src3 -> nvicirq = 0; read 0x030 -> 0xFFF00013.
  - Add src5 -> nvicirq = 1 (masked).
  - Add src0 -> nvicirq = 0; read -> 0xFFF00010.
  - Drop src0, write 0x030 -> int3 remains in service, nvicirq = 1.
  - Drop src3, write 0x030 -> nvicirq = 0; read -> 0xFFF00015.
- Simultaneous src6 + src7 -> read 0x030 returns 0xFFF00016.
- Disable all VectCntl, assert src3 -> read 0x030 returns 0xFFF00000.
